// File: rtl/trb_pkg.sv
// Shared trace ring buffer types and sizing used by the logger-side scheduler.
package trb_pkg;

    localparam int TRB_WIDTH      = 16;
    localparam int TRB_ADDR_WIDTH = 3;
    localparam int TRB_DEPTH      = 2 ** TRB_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ring_ptr.sv
// Wrapping pointer register with increment enable and synchronous clear.
module ring_ptr #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Natural overflow of the WIDTH-bit sum gives the modulo-DEPTH wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/trace_log_scheduler.sv
// Logger-side sequencer for the trace ring buffer: owns read/write pointers,
// fill count, drop counter and the egress register in front of MemoryController.
module trace_log_scheduler
    import trb_pkg::*;
#(
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      CLK_I,
    input  logic                      RST_NI,
    input  logic                      ARM_I,
    input  logic                      STOP_I,
    output logic [1:0]                STATE_O,
    input  logic                      RW_TURN_I,
    input  logic                      WRITE_ALLOW_I,
    input  logic                      READ_ALLOW_I,
    output logic [TRB_ADDR_WIDTH-1:0] READ_PTR_O,
    output logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_O,
    output logic                      LOGGER_WRITE_O,
    output logic [TRB_WIDTH-1:0]      LOGGER_DATA_O,
    input  logic [TRB_WIDTH-1:0]      LOGGER_DATA_I,
    input  logic                      TRACE_VALID_I,
    input  logic [TRB_WIDTH-1:0]      TRACE_DATA_I,
    output logic                      TRACE_READY_O,
    output logic                      OUT_VALID_O,
    output logic [TRB_WIDTH-1:0]      OUT_DATA_O,
    input  logic                      OUT_READY_I,
    output logic [TRB_ADDR_WIDTH:0]   FILL_O,
    output logic                      FULL_O,
    output logic                      EMPTY_O,
    output logic [DROP_CNT_WIDTH-1:0] DROPPED_O
);

    localparam int FW = TRB_ADDR_WIDTH + 1;

    sched_state_e              state_q, state_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      out_valid_q, out_valid_d;
    logic [TRB_WIDTH-1:0]      out_data_q, out_data_d;
    logic                      rd_pending_q, rd_pending_d;

    logic in_run;
    logic in_read_state;
    logic full;
    logic empty;
    logic wr_fire;
    logic rd_issue;
    logic clear_ptrs;

    assign in_run        = (state_q == RUN);
    assign in_read_state = (state_q == RUN) || (state_q == DRAIN);
    assign full          = (fill_q == FW'(TRB_DEPTH));
    assign empty         = (fill_q == '0);

    assign TRACE_READY_O = in_run & RW_TURN_I & WRITE_ALLOW_I & ~full;
    assign wr_fire       = TRACE_READY_O & TRACE_VALID_I;

    // A read may only launch when nothing is in flight and the egress register
    // will be free by the time the read data lands next cycle.
    assign rd_issue = in_read_state & RW_TURN_I & READ_ALLOW_I & ~empty
                    & ~rd_pending_q & (~out_valid_q | OUT_READY_I);

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        drop_d       = drop_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        rd_pending_d = rd_issue;
        clear_ptrs   = 1'b0;

        if (wr_fire && !rd_issue) begin
            fill_d = fill_q + FW'(1);
        end else if (rd_issue && !wr_fire) begin
            fill_d = fill_q - FW'(1);
        end

        if (in_run && TRACE_VALID_I && full && RW_TURN_I && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end

        if (rd_pending_q) begin
            out_valid_d = 1'b1;
            out_data_d  = LOGGER_DATA_I;
        end else if (out_valid_q && OUT_READY_I) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ARM_I) begin
                    state_d      = RUN;
                    clear_ptrs   = 1'b1;
                    fill_d       = '0;
                    drop_d       = '0;
                    out_valid_d  = 1'b0;
                    out_data_d   = '0;
                    rd_pending_d = 1'b0;
                end
            end
            RUN: begin
                if (STOP_I) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty && !rd_pending_q && !out_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            drop_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            drop_q       <= drop_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    ring_ptr #(.WIDTH(TRB_ADDR_WIDTH)) u_write_ptr (
        .clk     (CLK_I),
        .rst_n   (RST_NI),
        .clear_i (clear_ptrs),
        .inc_i   (wr_fire),
        .ptr_o   (WRITE_PTR_O)
    );

    ring_ptr #(.WIDTH(TRB_ADDR_WIDTH)) u_read_ptr (
        .clk     (CLK_I),
        .rst_n   (RST_NI),
        .clear_i (clear_ptrs),
        .inc_i   (rd_issue),
        .ptr_o   (READ_PTR_O)
    );

    assign STATE_O        = state_q;
    assign LOGGER_WRITE_O = wr_fire;
    assign LOGGER_DATA_O  = wr_fire ? TRACE_DATA_I : '0;
    assign OUT_VALID_O    = out_valid_q;
    assign OUT_DATA_O     = out_data_q;
    assign FILL_O         = fill_q;
    assign FULL_O         = full;
    assign EMPTY_O        = empty;
    assign DROPPED_O      = drop_q;

endmodule

// File: tb/tb_trace_log_scheduler.sv
// Directed self-checking bench for trace_log_scheduler with a small
// MemoryController-side memory model supplying read data.
module tb_trace_log_scheduler;
    import trb_pkg::*;

    localparam int AW = TRB_ADDR_WIDTH;
    localparam int W  = TRB_WIDTH;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          stop;
    logic [1:0]    state;
    logic          turn;
    logic          write_allow;
    logic          read_allow;
    logic [AW-1:0] read_ptr;
    logic [AW-1:0] write_ptr;
    logic          logger_write;
    logic [W-1:0]  logger_data;
    logic [W-1:0]  rdata;
    logic          trace_valid;
    logic [W-1:0]  trace_data;
    logic          trace_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [AW:0]   fill;
    logic          full;
    logic          empty;
    logic [DW-1:0] dropped;

    logic [W-1:0]  mem [TRB_DEPTH];

    int total = 0;
    int bad   = 0;

    trace_log_scheduler #(.DROP_CNT_WIDTH(DW)) dut (
        .CLK_I          (clk),
        .RST_NI         (rst_n),
        .ARM_I          (arm),
        .STOP_I         (stop),
        .STATE_O        (state),
        .RW_TURN_I      (turn),
        .WRITE_ALLOW_I  (write_allow),
        .READ_ALLOW_I   (read_allow),
        .READ_PTR_O     (read_ptr),
        .WRITE_PTR_O    (write_ptr),
        .LOGGER_WRITE_O (logger_write),
        .LOGGER_DATA_O  (logger_data),
        .LOGGER_DATA_I  (rdata),
        .TRACE_VALID_I  (trace_valid),
        .TRACE_DATA_I   (trace_data),
        .TRACE_READY_O  (trace_ready),
        .OUT_VALID_O    (out_valid),
        .OUT_DATA_O     (out_data),
        .OUT_READY_I    (out_ready),
        .FILL_O         (fill),
        .FULL_O         (full),
        .EMPTY_O        (empty),
        .DROPPED_O      (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory controller model: writes on strobe, read data one cycle after the pointer.
    always @(posedge clk) begin
        if (logger_write) mem[write_ptr] <= logger_data;
        rdata <= mem[read_ptr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        arm = 0; stop = 0; turn = 0; write_allow = 1; read_allow = 0;
        trace_valid = 0; trace_data = '0; out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        quiet_inputs();
        #3;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        total++; if (fill !== '0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL reset_fill: got fill=%0d empty=%b full=%b expected 0/1/0", fill, empty, full); end
        total++; if (read_ptr !== '0 || write_ptr !== '0) begin bad++; $display("[TB] FAIL reset_ptrs: got rd=%0d wr=%0d expected 0/0", read_ptr, write_ptr); end
        total++; if (out_valid !== 1'b0 || out_data !== '0 || dropped !== '0) begin bad++; $display("[TB] FAIL reset_egress: got v=%b d=%h drop=%0d expected 0/0/0", out_valid, out_data, dropped); end
        total++; if (trace_ready !== 1'b0 || logger_write !== 1'b0 || logger_data !== '0) begin bad++; $display("[TB] FAIL reset_write: got rdy=%b wr=%b d=%h expected 0/0/0", trace_ready, logger_write, logger_data); end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_writes();
        int k = 0;
        arm = 1;
        step();
        arm = 0;
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL arm_state: got %0d expected 1", state); end
        for (int c = 0; c < 16; c++) begin
            turn = (c % 2 == 0);
            trace_valid = turn;
            trace_data = 16'hA000 | 16'(k);
            #1;
            total++;
            if (turn) begin
                if (logger_write !== 1'b1 || write_ptr !== AW'(k) || logger_data !== trace_data) begin
                    bad++; $display("[TB] FAIL write_%0d: got wr=%b ptr=%0d d=%h expected 1/%0d/%h", k, logger_write, write_ptr, logger_data, k, trace_data);
                end
                k++;
            end else if (logger_write !== 1'b0 || trace_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL write_offturn: got wr=%b rdy=%b expected 0/0", logger_write, trace_ready);
            end
            step();
        end
        trace_valid = 0;
        total++; if (fill !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_after_writes: got fill=%0d full=%b empty=%b expected 8/1/0", fill, full, empty); end
    endtask

    task automatic test_full_drop();
        for (int c = 0; c < 10; c++) begin
            turn = (c % 2 == 0);
            trace_valid = 1;
            trace_data = 16'hEEEE;
            #1;
            total++; if (trace_ready !== 1'b0 || logger_write !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got rdy=%b wr=%b expected 0/0", trace_ready, logger_write); end
            step();
        end
        trace_valid = 0;
        total++; if (dropped !== 16'd5) begin bad++; $display("[TB] FAIL dropped: got %0d expected 5", dropped); end
        total++; if (fill !== 4'd8 || full !== 1'b1) begin bad++; $display("[TB] FAIL full_hold: got fill=%0d full=%b expected 8/1", fill, full); end
    endtask

    task automatic test_read_out();
        int n = 0;
        read_allow = 1;
        out_ready = 1;
        for (int c = 0; c < 80 && n < 8; c++) begin
            turn = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                total++; if (out_data !== (16'hA000 | 16'(n))) begin bad++; $display("[TB] FAIL read_%0d: got %h expected %h", n, out_data, 16'hA000 | 16'(n)); end
                n++;
            end
            step();
        end
        total++; if (n != 8) begin bad++; $display("[TB] FAIL read_count: got %0d expected 8", n); end
        total++; if (empty !== 1'b1 || fill !== '0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL read_empty: got empty=%b fill=%0d v=%b expected 1/0/0", empty, fill, out_valid); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int recv = 0;
        read_allow = 1;
        out_ready = 1;
        for (int c = 0; c < 120 && recv < 12; c++) begin
            turn = (c % 2 == 0);
            trace_valid = turn && (sent < 12);
            trace_data = 16'hB000 | 16'(sent);
            #1;
            if (logger_write) begin
                total++; if (write_ptr !== AW'(sent) || logger_data !== trace_data) begin bad++; $display("[TB] FAIL wrap_write_%0d: got ptr=%0d d=%h expected %0d/%h", sent, write_ptr, logger_data, sent % 8, trace_data); end
                sent++;
            end
            if (out_valid) begin
                total++; if (out_data !== (16'hB000 | 16'(recv))) begin bad++; $display("[TB] FAIL wrap_read_%0d: got %h expected %h", recv, out_data, 16'hB000 | 16'(recv)); end
                recv++;
            end
            step();
        end
        trace_valid = 0;
        total++; if (sent != 12 || recv != 12) begin bad++; $display("[TB] FAIL wrap_count: got sent=%0d recv=%0d expected 12/12", sent, recv); end
        total++; if (fill !== '0 || read_ptr !== 3'd4 || write_ptr !== 3'd4) begin bad++; $display("[TB] FAIL wrap_final: got fill=%0d rd=%0d wr=%0d expected 0/4/4", fill, read_ptr, write_ptr); end
    endtask

    task automatic test_stop_drain();
        int k = 0;
        int n = 0;
        read_allow = 0;
        out_ready = 1;
        for (int c = 0; c < 6; c++) begin
            turn = (c % 2 == 0);
            trace_valid = turn;
            trace_data = 16'hC000 | 16'(k);
            step();
            if (turn) k++;
        end
        trace_valid = 0;
        turn = 0;
        total++; if (fill !== 4'd3) begin bad++; $display("[TB] FAIL stop_fill: got %0d expected 3", fill); end
        stop = 1;
        step();
        stop = 0;
        total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL stop_state: got %0d expected 2", state); end
        arm = 1;
        step();
        arm = 0;
        total++; if (state !== 2'd2 || fill !== 4'd3) begin bad++; $display("[TB] FAIL arm_in_drain: got state=%0d fill=%0d expected 2/3", state, fill); end
        read_allow = 1;
        for (int c = 0; c < 60 && state != 2'd0; c++) begin
            turn = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                total++; if (out_data !== (16'hC000 | 16'(n))) begin bad++; $display("[TB] FAIL drain_%0d: got %h expected %h", n, out_data, 16'hC000 | 16'(n)); end
                n++;
            end
            step();
        end
        total++; if (n != 3 || state !== 2'd0 || empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_done: got n=%0d state=%0d empty=%b expected 3/0/1", n, state, empty); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        quiet_inputs();
        arm = 1;
        step();
        arm = 0;
        total++; if (state !== 2'd1 || dropped !== '0) begin bad++; $display("[TB] FAIL rearm: got state=%0d drop=%0d expected 1/0", state, dropped); end
        for (int c = 0; c < 10; c++) begin
            turn = (c % 2 == 0);
            trace_valid = turn;
            trace_data = 16'hD000 | 16'(k);
            step();
            if (turn) k++;
        end
        trace_valid = 0;
        turn = 1;
        read_allow = 1;
        step();
        turn = 0;
        read_allow = 0;
        step();
        total++; if (out_valid !== 1'b1 || fill !== 4'd4 || out_data !== 16'hD000) begin bad++; $display("[TB] FAIL pre_reset: got v=%b fill=%0d d=%h expected 1/4/d000", out_valid, fill, out_data); end
        turn = 1;
        write_allow = 1;
        trace_valid = 1;
        trace_data = 16'h1234;
        rst_n = 0;
        #1;
        total++; if (state !== 2'd0 || fill !== '0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_state: got st=%0d fill=%0d empty=%b full=%b expected 0/0/1/0", state, fill, empty, full); end
        total++; if (out_valid !== 1'b0 || out_data !== '0 || dropped !== '0 || read_ptr !== '0 || write_ptr !== '0) begin bad++; $display("[TB] FAIL mid_reset_egress: got v=%b d=%h drop=%0d rd=%0d wr=%0d expected all 0", out_valid, out_data, dropped, read_ptr, write_ptr); end
        total++; if (trace_ready !== 1'b0 || logger_write !== 1'b0 || logger_data !== '0) begin bad++; $display("[TB] FAIL mid_reset_write: got rdy=%b wr=%b d=%h expected 0/0/0", trace_ready, logger_write, logger_data); end
        quiet_inputs();
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_writes();
        test_full_drop();
        test_read_out();
        test_wrap();
        test_stop_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
